nibbler_prog_loader: RTL and testbench

NIBBLER_PROG_LOADER -- requirements
Module: nibbler_prog_loader

---
 rtl/nibbler_prog_loader.sv | 117 +++++++++++
 tb/tb_nibbler_prog_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nibbler_prog_loader.sv
// Program loader for the NIBBLER core. It assembles high/low nibble pairs into
// instruction words and writes them to program memory while holding the core in reset.
module nibbler_prog_loader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [3:0]        in_nibble,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] HI    = 3'd1;
  localparam logic [2:0] LO    = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              last_q, last_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              xfer;

  // Ready depends only on state so upstream never sees a combinational loop.
  assign in_ready = (state_q == HI) || (state_q == LO);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          addr_d  = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = HI;
        end
      end
      HI: begin
        if (xfer) begin
          wdata_d[DATA_W-1 -: 4] = in_nibble;
          state_d                = LO;
        end
      end
      LO: begin
        if (xfer) begin
          wdata_d[3:0] = in_nibble;
          last_d       = in_last;
          state_d      = WRITE;
        end
      end
      WRITE: begin
        count_d = count_q + CNT_ONE;
        if (last_q) begin
          state_d = DONE;
        end else if (addr_q == ADDR_MAX) begin
          // Address space exhausted: stop rather than wrap over word 0.
          ovf_d   = 1'b1;
          state_d = DONE;
        end else begin
          addr_d  = addr_q + ADDR_ONE;
          state_d = HI;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      last_q  <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign mem_we     = (state_q == WRITE);
  assign cpu_hold   = (state_q != DONE);
  assign load_done  = (state_q == DONE);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign overflow   = ovf_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_nibbler_prog_loader.sv
// Scoreboard bench for nibbler_prog_loader: a 12-bit-address instance and a
// 2-bit-address instance share stimulus; the idle one is held in reset.
module tb_nibbler_prog_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, start, in_valid, in_last, sel;
  logic [3:0] in_nibble;

  logic        rdy_a, we_a, hold_a, done_a, ovf_a;
  logic [11:0] addr_a;
  logic [7:0]  wd_a;
  logic [12:0] cnt_a;

  logic        rdy_b, we_b, hold_b, done_b, ovf_b;
  logic [1:0]  addr_b;
  logic [7:0]  wd_b;
  logic [2:0]  cnt_b;

  nibbler_prog_loader #(.ADDR_W(12), .DATA_W(8)) dut_a (
    .clk(clk), .reset(rst_a), .start(start), .in_valid(in_valid),
    .in_nibble(in_nibble), .in_last(in_last), .in_ready(rdy_a),
    .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wd_a), .cpu_hold(hold_a),
    .load_done(done_a), .overflow(ovf_a), .word_count(cnt_a)
  );

  nibbler_prog_loader #(.ADDR_W(2), .DATA_W(8)) dut_b (
    .clk(clk), .reset(rst_b), .start(start), .in_valid(in_valid),
    .in_nibble(in_nibble), .in_last(in_last), .in_ready(rdy_b),
    .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wd_b), .cpu_hold(hold_b),
    .load_done(done_b), .overflow(ovf_b), .word_count(cnt_b)
  );

  logic ready, done;
  assign ready = sel ? rdy_b : rdy_a;
  assign done  = sel ? done_b : done_a;

  typedef struct {
    logic        sel;
    logic [11:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (we_a || we_b) begin
      exp_t        e;
      logic [11:0] a;
      logic [7:0]  d;
      a = we_b ? {10'b0, addr_b} : addr_a;
      d = we_b ? wd_b : wd_a;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write inst=%0d addr=%0h data=%0h", we_b, a, d);
      end else begin
        e = exp_q.pop_front();
        if (e.sel !== we_b || e.addr !== a || e.data !== d) begin
          errors++;
          $display("FAIL write inst=%0d addr=%0h data=%0h required inst=%0d addr=%0h data=%0h",
                   we_b, a, d, e.sel, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic xfer(input logic [3:0] n, input logic l);
    int t;
    t = 0;
    in_valid  = 1'b1;
    in_nibble = n;
    in_last   = l;
    while (!ready && t < 20) begin
      tick(1);
      t++;
    end
    chk("xfer_ready", {31'b0, ready}, 1);
    tick(1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic word(input logic [3:0] hi, input logic [3:0] lo, input logic last,
                      input logic hi_last, input logic [11:0] a);
    exp_t e;
    e.sel  = sel;
    e.addr = a;
    e.data = {hi, lo};
    exp_q.push_back(e);
    xfer(hi, hi_last);
    xfer(lo, last);
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (!done && t < 10) begin
      tick(1);
      t++;
    end
    chk(name, {31'b0, done}, 1);
  endtask

  logic [3:0] his[7] = '{4'h4, 4'h4, 4'h4, 4'h4, 4'hE, 4'hA, 4'h2};
  logic [3:0] los[7] = '{4'h0, 4'h4, 4'h0, 4'hF, 4'hF, 4'h1, 4'h1};

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 0; rst_a = 1; rst_b = 1; start = 0;
    in_valid = 0; in_nibble = 0; in_last = 0;
    #1;
    rst_a = 0; rst_b = 0;
    tick(2);
    chk("rst_ready", {31'b0, rdy_a}, 0);
    chk("rst_hold",  {31'b0, hold_a}, 1);
    chk("rst_we",    {31'b0, we_a}, 0);
    chk("rst_done",  {31'b0, done_a}, 0);
    chk("rst_ovf",   {31'b0, ovf_a}, 0);
    chk("rst_count", {19'b0, cnt_a}, 0);
    chk("rst_addr",  {20'b0, addr_a}, 0);
    chk("rst_wdata", {24'b0, wd_a}, 0);

    rst_a = 1;
    tick(2);
    chk("idle_ready", {31'b0, rdy_a}, 0);
    pulse_start();
    chk("hi_hold",  {31'b0, hold_a}, 1);
    chk("hi_ready", {31'b0, rdy_a}, 1);

    // Seven-word program, last flagged on the final low nibble.
    for (int i = 0; i < 7; i++) word(his[i], los[i], (i == 6), 1'b0, 12'(i));
    wait_done("prog_done");
    chk("prog_hold",  {31'b0, hold_a}, 0);
    chk("prog_count", {19'b0, cnt_a}, 7);
    chk("prog_addr",  {20'b0, addr_a}, 6);
    chk("prog_ovf",   {31'b0, ovf_a}, 0);
    chk("prog_ready", {31'b0, rdy_a}, 0);

    // Restart from DONE.
    pulse_start();
    chk("restart_hold",  {31'b0, hold_a}, 1);
    chk("restart_done",  {31'b0, done_a}, 0);
    chk("restart_count", {19'b0, cnt_a}, 0);

    // Stall between high and low nibble.
    begin
      exp_t e;
      e.sel = 0; e.addr = 12'h000; e.data = 8'h5A;
      exp_q.push_back(e);
    end
    xfer(4'h5, 1'b0);
    tick(5);
    chk("gap_ready", {31'b0, rdy_a}, 1);
    chk("gap_count", {19'b0, cnt_a}, 0);
    xfer(4'hA, 1'b0);

    // start during WRITE is ignored; last on a high nibble is ignored.
    pulse_start();
    word(4'h3, 4'hC, 1'b0, 1'b1, 12'h001);
    tick(2);
    chk("hilast_done",  {31'b0, done_a}, 0);
    chk("hilast_count", {19'b0, cnt_a}, 2);
    word(4'h7, 4'h7, 1'b1, 1'b0, 12'h002);
    wait_done("second_done");
    chk("second_count", {19'b0, cnt_a}, 3);

    // Reset asserted while waiting for a low nibble.
    pulse_start();
    word(4'h1, 4'h2, 1'b0, 1'b0, 12'h000);
    word(4'h3, 4'h4, 1'b0, 1'b0, 12'h001);
    xfer(4'h9, 1'b0);
    rst_a = 0;
    #1;
    chk("abort_hold",  {31'b0, hold_a}, 1);
    chk("abort_ready", {31'b0, rdy_a}, 0);
    chk("abort_count", {19'b0, cnt_a}, 0);
    chk("abort_addr",  {20'b0, addr_a}, 0);
    tick(3);
    rst_a = 1;
    tick(3);
    chk("post_abort_ready", {31'b0, rdy_a}, 0);
    chk("post_abort_hold",  {31'b0, hold_a}, 1);
    pulse_start();
    word(4'h6, 4'h6, 1'b1, 1'b0, 12'h000);
    wait_done("reload_done");
    chk("reload_count", {19'b0, cnt_a}, 1);
    chk("reload_addr",  {20'b0, addr_a}, 0);

    // Overflow on the 2-bit-address instance.
    rst_a = 0;
    sel   = 1;
    rst_b = 1;
    tick(1);
    pulse_start();
    for (int i = 0; i < 4; i++) word(4'(i + 1), 4'h8, 1'b0, 1'b0, 12'(i));
    wait_done("ovf_done");
    chk("ovf_flag",  {31'b0, ovf_b}, 1);
    chk("ovf_count", {29'b0, cnt_b}, 4);
    chk("ovf_addr",  {30'b0, addr_b}, 3);
    chk("ovf_hold",  {31'b0, hold_b}, 0);
    in_valid  = 1'b1;
    in_nibble = 4'h5;
    tick(3);
    chk("ovf_ready", {31'b0, rdy_b}, 0);
    in_valid = 1'b0;
    chk("ovf_count_after", {29'b0, cnt_b}, 4);

    tick(3);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
